// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write_back scheduler slice.
// Contents:
//   state_t          scheduler FSM states (IDLE, ISSUE, WAIT, DONE)
//   WB_ADDR_W        default destination address width (matches write_back)
//   WB_ROWS_W        default row-count width
//   WB_STRIDE_W      default per-row address increment width
//   WB_TIMEOUT       default maximum number of cycles spent waiting for wb_done
//   cnt_width()      bit width needed to hold a count of 0..max_val
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WB_ADDR_W   = 10;
  localparam int unsigned WB_ROWS_W   = 6;
  localparam int unsigned WB_STRIDE_W = 5;
  localparam int unsigned WB_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Never returns less than one bit, so a TIMEOUT of 1 still gets a register.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Clear/enable cycle counter used by the scheduler to bound its wait for
// wb_done. expired is high during the enabled cycle in which the counter
// reaches its last value, so an enabled stretch lasts at most TIMEOUT cycles.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   clear    in  restart the count from zero on the next edge
//   enable   in  count this cycle (held high while waiting)
//   expired  out TIMEOUT enabled cycles have now elapsed
// -----------------------------------------------------------------------------
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned      CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_scheduler.sv
// -----------------------------------------------------------------------------
// wb_scheduler
// Sequences the write_back unit through a job of N result rows. A job
// descriptor (base, rows, stride) is taken through a valid/ready handshake;
// each row gets a single-cycle wb_start with an incrementing destination
// address, and the next row is only issued after wb_done. Completion, abort
// and timeout are reported; every output is driven from a register.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   job_valid      in  descriptor valid
//   job_ready      out descriptor can be taken (IDLE only)
//   job_base       in  first destination address
//   job_rows       in  number of rows in the job
//   job_stride     in  address increment per row
//   abort          in  cancel the running job
//   wb_start       out one-cycle start pulse to write_back
//   wb_addr        out destination address of the current row
//   wb_done        in  row complete from write_back
//   busy           out any state other than IDLE
//   job_done       out one-cycle pulse when a job ends for any reason
//   err_timeout    out sticky, last job ended by timeout
//   err_abort      out sticky, last job ended by abort
//   rows_written   out rows completed in the current or last job
// -----------------------------------------------------------------------------
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W   = WB_ADDR_W,
  parameter int unsigned ROWS_W   = WB_ROWS_W,
  parameter int unsigned STRIDE_W = WB_STRIDE_W,
  parameter int unsigned TIMEOUT  = WB_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ADDR_W-1:0]   job_base,
  input  logic [ROWS_W-1:0]   job_rows,
  input  logic [STRIDE_W-1:0] job_stride,
  input  logic                abort,
  output logic                wb_start,
  output logic [ADDR_W-1:0]   wb_addr,
  input  logic                wb_done,
  output logic                busy,
  output logic                job_done,
  output logic                err_timeout,
  output logic                err_abort,
  output logic [ROWS_W-1:0]   rows_written
);

  state_t              state;
  state_t              state_next;
  logic [ROWS_W-1:0]   rows_left;
  logic [ROWS_W-1:0]   rows_left_next;
  logic [STRIDE_W-1:0] stride;
  logic [STRIDE_W-1:0] stride_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [ROWS_W-1:0]   rows_written_next;
  logic                wb_start_next;
  logic                job_done_next;
  logic                err_timeout_next;
  logic                err_abort_next;
  logic                tmo_clear;
  logic                tmo_enable;
  logic                tmo_expired;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so that the registers below present them in that state's cycle.
  // wb_addr doubles as the running address register and is only moved when the
  // next row is issued, which keeps it stable from ISSUE through WAIT.
  always_comb begin
    state_next        = state;
    rows_left_next    = rows_left;
    stride_next       = stride;
    addr_next         = wb_addr;
    rows_written_next = rows_written;
    wb_start_next     = 1'b0;
    job_done_next     = 1'b0;
    err_timeout_next  = err_timeout;
    err_abort_next    = err_abort;
    tmo_clear         = 1'b0;
    tmo_enable        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (job_valid && job_ready) begin
          addr_next         = job_base;
          rows_left_next    = job_rows;
          stride_next       = job_stride;
          rows_written_next = '0;
          err_timeout_next  = 1'b0;
          err_abort_next    = 1'b0;
          if (job_rows == '0) begin
            // Empty job: DONE is entered without the pulse; it is raised on
            // the following cycle.
            state_next = ST_DONE;
          end else begin
            state_next    = ST_ISSUE;
            wb_start_next = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        tmo_clear = 1'b1;
        if (abort) begin
          err_abort_next = 1'b1;
          job_done_next  = 1'b1;
          state_next     = ST_DONE;
        end else begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tmo_enable = 1'b1;
        // wb_done wins over abort, abort wins over timeout. A completed row is
        // always counted, and finishing the last row is a clean completion.
        if (wb_done) begin
          rows_written_next = rows_written + ROWS_W'(1);
          rows_left_next    = rows_left - ROWS_W'(1);
          if (rows_left == ROWS_W'(1)) begin
            job_done_next = 1'b1;
            state_next    = ST_DONE;
          end else if (abort) begin
            err_abort_next = 1'b1;
            job_done_next  = 1'b1;
            state_next     = ST_DONE;
          end else begin
            addr_next     = wb_addr + ADDR_W'(stride);
            wb_start_next = 1'b1;
            state_next    = ST_ISSUE;
          end
        end else if (abort) begin
          err_abort_next = 1'b1;
          job_done_next  = 1'b1;
          state_next     = ST_DONE;
        end else if (tmo_expired) begin
          err_timeout_next = 1'b1;
          job_done_next    = 1'b1;
          state_next       = ST_DONE;
        end
      end

      ST_DONE: begin
        // Leave once the pulse has been shown; otherwise show it now.
        if (job_done) begin
          state_next = ST_IDLE;
        end else begin
          job_done_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers. busy/job_ready follow the state being entered
  // so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rows_left    <= '0;
      stride       <= '0;
      wb_addr      <= '0;
      rows_written <= '0;
      wb_start     <= 1'b0;
      job_done     <= 1'b0;
      err_timeout  <= 1'b0;
      err_abort    <= 1'b0;
      busy         <= 1'b0;
      job_ready    <= 1'b1;
    end else begin
      state        <= state_next;
      rows_left    <= rows_left_next;
      stride       <= stride_next;
      wb_addr      <= addr_next;
      rows_written <= rows_written_next;
      wb_start     <= wb_start_next;
      job_done     <= job_done_next;
      err_timeout  <= err_timeout_next;
      err_abort    <= err_abort_next;
      busy         <= (state_next != ST_IDLE);
      job_ready    <= (state_next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wb_scheduler
// Scoreboard bench for wb_scheduler. Stimulus pushes the expected wb_start
// events (address, cycle) and job_done events (cycle, rows, flags) into
// queues; a monitor pops and compares whenever the DUT raises either output.
// A small write_back model answers each wb_start with wb_done after a
// configurable latency.
// -----------------------------------------------------------------------------
module tb_wb_scheduler;

  localparam int ADDR_W   = 10;
  localparam int ROWS_W   = 6;
  localparam int STRIDE_W = 5;
  localparam int TIMEOUT  = 8;

  typedef struct {
    int addr;
    int cyc;
  } start_exp_t;

  typedef struct {
    int cyc;
    int rows;
    int tmo;
    int abt;
  } done_exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                job_valid = 1'b0;
  logic                job_ready;
  logic [ADDR_W-1:0]   job_base = '0;
  logic [ROWS_W-1:0]   job_rows = '0;
  logic [STRIDE_W-1:0] job_stride = '0;
  logic                abort = 1'b0;
  logic                wb_start;
  logic [ADDR_W-1:0]   wb_addr;
  logic                wb_done;
  logic                busy;
  logic                job_done;
  logic                err_timeout;
  logic                err_abort;
  logic [ROWS_W-1:0]   rows_written;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  start_exp_t exp_start[$];
  done_exp_t  exp_done[$];

  // write_back model
  logic model_en  = 1'b1;
  int   model_lat = 1;
  int   model_cnt = 0;

  wb_scheduler #(
    .ADDR_W   (ADDR_W),
    .ROWS_W   (ROWS_W),
    .STRIDE_W (STRIDE_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_base     (job_base),
    .job_rows     (job_rows),
    .job_stride   (job_stride),
    .abort        (abort),
    .wb_start     (wb_start),
    .wb_addr      (wb_addr),
    .wb_done      (wb_done),
    .busy         (busy),
    .job_done     (job_done),
    .err_timeout  (err_timeout),
    .err_abort    (err_abort),
    .rows_written (rows_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt <= 0;
    end else if (wb_start && model_en) begin
      model_cnt <= model_lat;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
    end
  end

  assign wb_done = (model_cnt == 1);

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event not expected at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    start_exp_t se;
    done_exp_t  de;
    if (rst_n) begin
      if (wb_start) begin
        if (exp_start.size() == 0) begin
          fail_event("unexpected_wb_start");
        end else begin
          se = exp_start.pop_front();
          check_output("wb_addr", int'(wb_addr), se.addr);
          check_output("wb_start_cycle", cyc, se.cyc);
        end
      end
      if (job_done) begin
        if (exp_done.size() == 0) begin
          fail_event("unexpected_job_done");
        end else begin
          de = exp_done.pop_front();
          if (de.cyc >= 0) check_output("job_done_cycle", cyc, de.cyc);
          check_output("rows_written", int'(rows_written), de.rows);
          check_output("err_timeout", int'(err_timeout), de.tmo);
          check_output("err_abort", int'(err_abort), de.abt);
        end
      end
    end
  end

  // Presents one descriptor; t returns the cycle in which it is sampled.
  task automatic apply_stimulus(input int base, input int rows, input int stride, output int t);
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_event("job_ready_timeout");
    job_valid  = 1'b1;
    job_base   = ADDR_W'(base);
    job_rows   = ROWS_W'(rows);
    job_stride = STRIDE_W'(stride);
    t = cyc;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic push_start(input int addr, input int c);
    start_exp_t se;
    se.addr = addr;
    se.cyc  = c;
    exp_start.push_back(se);
  endtask

  task automatic push_done(input int c, input int rows, input int tmo, input int abt);
    done_exp_t de;
    de.cyc  = c;
    de.rows = rows;
    de.tmo  = tmo;
    de.abt  = abt;
    exp_done.push_back(de);
  endtask

  // Expected events of a job that runs to completion with a 1-cycle write_back.
  task automatic push_clean_job(input int t, input int base, input int rows, input int stride);
    for (int i = 0; i < rows; i++) begin
      push_start((base + i * stride) % 1024, t + 1 + 2 * i);
    end
    push_done((rows == 0) ? t + 2 : t + 2 * rows + 1, rows, 0, 0);
  endtask

  task automatic wait_cycle(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic wait_idle(input string name);
    int  n = 0;
    bit  ok = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      n++;
      ok = job_ready && (exp_start.size() == 0) && (exp_done.size() == 0);
    end
    if (!ok) fail_event(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_job_ready"}, int'(job_ready), 1);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_wb_start"}, int'(wb_start), 0);
    check_output({tag, "_wb_addr"}, int'(wb_addr), 0);
    check_output({tag, "_job_done"}, int'(job_done), 0);
    check_output({tag, "_rows_written"}, int'(rows_written), 0);
    check_output({tag, "_err_timeout"}, int'(err_timeout), 0);
    check_output({tag, "_err_abort"}, int'(err_abort), 0);
  endtask

  initial begin
    int t;
    $display("[TB] wb_scheduler bench start");

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    #1;
    rst_n = 1'b1;

    // Basic three-row job.
    apply_stimulus(12'h010, 3, 16, t);
    push_clean_job(t, 12'h010, 3, 16);
    wait_idle("basic_job_complete");

    // Zero-row job: no wb_start, pulse two cycles after acceptance.
    apply_stimulus(12'h123, 0, 4, t);
    push_clean_job(t, 12'h123, 0, 4);
    wait_idle("zero_job_complete");

    // Timeout: write_back never answers.
    model_en = 1'b0;
    apply_stimulus(12'h200, 2, 1, t);
    push_start(12'h200, t + 1);
    push_done(-1, 0, 1, 0);
    wait_idle("timeout_job_complete");
    check_output("err_timeout_sticky", int'(err_timeout), 1);
    model_en = 1'b1;

    // Address wrap; also clears the sticky timeout flag on acceptance.
    apply_stimulus(12'h3F8, 2, 16, t);
    check_output("err_timeout_cleared", int'(err_timeout), 0);
    push_clean_job(t, 12'h3F8, 2, 16);
    wait_idle("wrap_job_complete");

    // Abort while waiting on row 2 of 4 (slow write_back).
    model_lat = 3;
    apply_stimulus(12'h040, 4, 8, t);
    push_start(12'h040, t + 1);
    push_start(12'h048, t + 5);
    push_done(t + 7, 1, 0, 1);
    wait_cycle(t + 6);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle("abort_job_complete");
    model_lat = 1;
    repeat (4) @(negedge clk);

    // Abort coinciding with the last wb_done: clean completion.
    apply_stimulus(12'h100, 2, 4, t);
    push_clean_job(t, 12'h100, 2, 4);
    wait_cycle(t + 4);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle("abort_coincident_complete");

    // Reset while waiting on the first row.
    apply_stimulus(12'h0A0, 3, 2, t);
    push_clean_job(t, 12'h0A0, 3, 2);
    wait_cycle(t + 2);
    check_output("busy_before_reset", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_start.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Job accepted after reset release.
    apply_stimulus(12'h055, 1, 1, t);
    push_clean_job(t, 12'h055, 1, 1);
    wait_idle("post_reset_job_complete");

    if (exp_start.size() != 0) fail_event("leftover_wb_start_expectations");
    if (exp_done.size() != 0) fail_event("leftover_job_done_expectations");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
Name: wb_scheduler

Overview:
- Sequences the write_back unit to store a job of N result rows.
- Accepts a job descriptor (base address, row count, stride) through a valid/ready handshake.
- Issues one single-cycle wb_start per row with an incrementing destination address, and waits for wb_done before issuing the next row.
- Sits between the array controller and write_back; reports completion, abort and timeout status.

Parameters:
- ADDR_W, 10, destination address width (matches write_back addr_des).
- ROWS_W, 6, width of the row-count field; up to 63 rows per job.
- STRIDE_W, 5, width of the per-row address increment.
- TIMEOUT, 255, maximum cycles spent in WAIT before the job is abandoned; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  scheduler can accept a job (high only in IDLE).
- job_base  in  ADDR_W  first destination address.
- job_rows  in  ROWS_W  number of rows to write.
- job_stride  in  STRIDE_W  address increment per row.
- abort  in  1  synchronous request to cancel the current job.
- wb_start  out  1  one-cycle start pulse to write_back.
- wb_addr  out  ADDR_W  destination address for the current row; held stable from ISSUE through WAIT.
- wb_done  in  1  row-complete indication from write_back.
- busy  out  1  high in any state other than IDLE.
- job_done  out  1  one-cycle pulse when a job ends for any reason.
- err_timeout  out  1  sticky; set when a job ends by timeout.
- err_abort  out  1  sticky; set when a job ends by abort.
- rows_written  out  ROWS_W  rows completed in the current or last job.

Behaviour:
- Reset values: all outputs 0, except job_ready = 1. State is IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - job_ready = 1.
  - On job_valid && job_ready: latch base, rows and stride; clear rows_written, err_timeout and err_abort.
  - If job_rows == 0, go to DONE; no wb_start is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - wb_start = 1 for exactly one cycle; wb_addr = current address.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - wb_start = 0; the timeout counter increments each cycle.
  - On wb_done: rows_written += 1 and the remaining count decrements.
  - If the remaining count reaches 0, go to DONE.
  - Otherwise address = (address + stride) mod 2^ADDR_W (wraps silently) and go to ISSUE.
  - wb_done sampled in ISSUE or IDLE is ignored. write_back holds done high for one cycle after start, so the scheduler only qualifies done in WAIT.
- Timeout: if the counter reaches TIMEOUT in WAIT without wb_done, set err_timeout and go to DONE.
- Abort: abort in ISSUE or WAIT sets err_abort and goes to DONE next cycle.
  - An abort in ISSUE still emits that cycle's wb_start.
  - abort in IDLE or DONE is ignored.
- Priority in WAIT when events coincide: wb_done > abort > timeout. The row is counted; if it was the last row, the job completes with no error flag.
- DONE: job_done = 1 for one cycle, then go to IDLE.
- Latency with write_back (done registered one cycle after start):
  - Accept at cycle T; first wb_start at T+1; wb_done at T+2; next wb_start at T+3.
  - An N-row job gives job_done at T+2N+1.
- Reset mid-job: immediate return to IDLE; wb_start drops asynchronously to 0.

Decomposition:
- Shared package wb_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE).
  - ADDR_W default.
  - TIMEOUT default.
- One natural sub-module: wb_timeout_cnt.
  - Clear/enable counter producing an expired flag at TIMEOUT.
- Address/row counters stay inline.

Test Plan:
- Basic job: base=0x010, rows=3, stride=16 with write_back attached.
  - wb_addr = 0x010, 0x020, 0x030 at wb_start cycles T+1, T+3, T+5.
  - job_done at T+7; rows_written = 3; no error flags.
- Zero rows: job_rows=0.
  - No wb_start; job_done at T+2; rows_written = 0.
- Wrap: base=0x3F8, rows=2, stride=16.
  - Second wb_addr = 0x008.
- Timeout: wb_done tied low, TIMEOUT=8.
  - One wb_start, then job_done with err_timeout = 1 and rows_written = 0.
  - err_timeout stays set until the next job is accepted.
- Abort and coincidence:
  - Abort in WAIT of row 2 of 4 → err_abort = 1, rows_written = 1, job_done next cycle.
  - Abort on the same cycle as the last wb_done → clean completion, err_abort = 0.
- Reset mid-job: assert rst_n low in WAIT.
  - All outputs immediately return to reset values.
  - A new job is accepted after release.
